// File: rtl/block_pkg.sv
// Shared constants for the merged front-end block stream: word fields, source codes, channel count.
package block_pkg;

  localparam int unsigned DATA_W   = 128;
  localparam int unsigned PERIOD_W = 48;
  localparam int unsigned SRC_HI   = 127;
  localparam int unsigned SRC_LO   = 125;
  localparam int unsigned NCH      = 5;

  typedef enum logic [2:0] {
    SRC_B1 = 3'd0,
    SRC_B2 = 3'd1,
    SRC_B3 = 3'd2,
    SRC_B4 = 3'd3,
    SRC_TT = 3'd4
  } src_t;

  function automatic logic src_valid(input logic [2:0] s);
    return s <= SRC_TT;
  endfunction

endpackage

// File: rtl/block_chan_fifo.sv
// Per-channel synchronous FIFO with registered pointers; output is read from storage (no fall-through).
module block_chan_fifo #(
  parameter int unsigned W     = 176,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;

  always_comb begin
    o_full  = (r_wr ^ r_rd) == {1'b1, {AW{1'b0}}};
    w_empty = (r_wr == r_rd);
    o_valid = ~w_empty;
    o_data  = r_mem[r_rd[AW-1:0]];
    w_push  = i_valid & ~o_full;
    w_pop   = i_ready & ~w_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr[AW-1:0]] <= i_data;
        r_wr                <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/block_demultiplexer.sv
// Splits the merged 128-bit stream into four block channels plus a time-tag channel,
// tagging each block word with the period of the most recent time tag.
module block_demultiplexer
  import block_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned ERR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic [NCH-1:0]          out_valid,
  input  logic [NCH-1:0]          out_ready,
  output logic [NCH*DATA_W-1:0]   out_data,
  output logic [NCH*PERIOD_W-1:0] out_period,
  output logic                    period_known,
  output logic [ERR_W-1:0]        tt_order_err,
  output logic [ERR_W-1:0]        src_err
);

  logic [2:0]          w_src;
  logic                w_src_ok;
  logic                w_is_tt;
  logic                w_accept;
  logic [NCH-1:0]      w_full;
  logic [NCH-1:0]      w_push;
  logic [PERIOD_W-1:0] w_push_period;
  logic [PERIOD_W-1:0] r_cur_period;
  logic                r_period_known;
  logic [ERR_W-1:0]    r_tt_order_err;
  logic [ERR_W-1:0]    r_src_err;

  // Invalid sources are always consumed so they can never wedge the stream.
  always_comb begin
    w_src    = in_data[SRC_HI:SRC_LO];
    w_src_ok = src_valid(w_src);
    w_is_tt  = (w_src == SRC_TT);
    in_ready = 1'b0;
    if (!rst) in_ready = w_src_ok ? ~w_full[w_src] : 1'b1;
    w_accept = in_valid & in_ready;
    w_push   = '0;
    if (w_accept && w_src_ok) w_push[w_src] = 1'b1;
    w_push_period = w_is_tt ? in_data[PERIOD_W-1:0] : r_cur_period;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_period   <= '0;
      r_period_known <= 1'b0;
      r_tt_order_err <= '0;
      r_src_err      <= '0;
    end else if (w_accept) begin
      if (!w_src_ok) begin
        if (r_src_err != '1) r_src_err <= r_src_err + 1'b1;
      end else if (w_is_tt) begin
        r_cur_period   <= in_data[PERIOD_W-1:0];
        r_period_known <= 1'b1;
        if (r_period_known && (in_data[PERIOD_W-1:0] <= r_cur_period) && (r_tt_order_err != '1))
          r_tt_order_err <= r_tt_order_err + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    block_chan_fifo #(
      .W     (DATA_W + PERIOD_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_push[k]),
      .i_data  ({in_data, w_push_period}),
      .o_full  (w_full[k]),
      .o_valid (out_valid[k]),
      .i_ready (out_ready[k]),
      .o_data  ({out_data[k*DATA_W +: DATA_W], out_period[k*PERIOD_W +: PERIOD_W]})
    );
  end

  assign period_known = r_period_known;
  assign tt_order_err = r_tt_order_err;
  assign src_err      = r_src_err;

endmodule

// File: tb/tb_block_demultiplexer.sv
// Scoreboard bench: stimulus pushes expected {data,period} per channel, a monitor pops on each output handshake.
module tb_block_demultiplexer;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [127:0]  in_data = '0;
  logic          in_ready;
  logic [4:0]    out_valid;
  logic [4:0]    out_ready = 5'h1f;
  logic [639:0]  out_data;
  logic [239:0]  out_period;
  logic          period_known;
  logic [15:0]   tt_order_err;
  logic [15:0]   src_err;

  int n_vec = 0;
  int n_err = 0;
  logic [175:0] q [5][$];

  always #5 clk = ~clk;

  block_demultiplexer #(.DEPTH(2), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_period(out_period),
    .period_known(period_known), .tt_order_err(tt_order_err), .src_err(src_err)
  );

  function automatic logic [127:0] mk(input logic [2:0] src, input logic [63:0] payload);
    return {src, 61'h0, payload};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the head of that channel's queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 5; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          n_vec++;
          if (q[k].size() == 0) begin
            n_err++;
            $display("FAIL unexpected_ch%0d: got data 0x%0h period 0x%0h expected nothing",
                     k, out_data[k*128 +: 128], out_period[k*48 +: 48]);
          end else begin
            logic [175:0] e;
            e = q[k].pop_front();
            if ({out_data[k*128 +: 128], out_period[k*48 +: 48]} !== e) begin
              n_err++;
              $display("FAIL ch%0d_word: got data 0x%0h period 0x%0h expected data 0x%0h period 0x%0h",
                       k, out_data[k*128 +: 128], out_period[k*48 +: 48], e[175:48], e[47:0]);
            end
          end
        end
      end
    end
  end

  // ch = 5 means the word is expected to be dropped.
  task automatic send(input logic [127:0] d, input logic [47:0] p, input int ch);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        if (ch < 5) q[ch].push_back({d, p});
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 for word 0x%0h", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(3);
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_in_ready", 64'(in_ready), 64'h0);
    chk("reset_counters", {32'h0, tt_order_err, src_err}, 64'h0);
    chk("reset_period_known", 64'(period_known), 64'h0);
    rst = 1'b0;
    idle(2);

    // Block word before any time tag carries period 0.
    send(mk(3'b000, 64'hA1), 48'h0, 0);
    idle(3);
    chk("pre_tt_period_known", 64'(period_known), 64'h0);
    chk("pre_tt_counters", {32'h0, tt_order_err, src_err}, 64'h0);

    // Time tag then two block words, all consumers ready.
    send(mk(3'b100, 64'h10), 48'h10, 4);
    chk("tt_latency_1cyc", 64'(out_valid[4]), 64'h1);
    send(mk(3'b001, 64'hB2), 48'h10, 1);
    chk("b2_latency_1cyc", 64'(out_valid[1]), 64'h1);
    send(mk(3'b011, 64'hB4), 48'h10, 3);
    chk("b4_latency_1cyc", 64'(out_valid[3]), 64'h1);
    idle(3);
    chk("period_known_set", 64'(period_known), 64'h1);

    // Backpressure on channel 0 with DEPTH=2.
    out_ready = 5'h1e;
    send(mk(3'b000, 64'hC1), 48'h10, 0);
    send(mk(3'b000, 64'hC2), 48'h10, 0);
    #3;
    chk("full_in_ready_low", 64'(in_ready), 64'h0);
    fork
      begin
        send(mk(3'b000, 64'hC3), 48'h10, 0);
        send(mk(3'b010, 64'hD3), 48'h10, 2);
      end
      begin
        idle(6);
        chk("stalled_b3_not_out", 64'(out_valid[2]), 64'h0);
        chk("stalled_in_ready", 64'(in_ready), 64'h0);
        chk("stalled_ch0_valid", 64'(out_valid[0]), 64'h1);
        out_ready = 5'h1f;
      end
    join
    idle(4);

    // Time-tag ordering errors: equal and decreasing both count.
    send(mk(3'b100, 64'h20), 48'h20, 4);
    send(mk(3'b100, 64'h20), 48'h20, 4);
    send(mk(3'b100, 64'h1F), 48'h1F, 4);
    send(mk(3'b001, 64'hE2), 48'h1F, 1);
    idle(3);
    chk("tt_order_err", 64'(tt_order_err), 64'h2);

    // Invalid source: consumed and counted, nothing forwarded.
    in_data = mk(3'b110, 64'h99);
    #1;
    chk("invalid_src_in_ready", 64'(in_ready), 64'h1);
    send(mk(3'b110, 64'h99), 48'h0, 5);
    idle(2);
    chk("src_err", 64'(src_err), 64'h1);
    chk("invalid_no_out_valid", 64'(out_valid), 64'h0);
    send(mk(3'b000, 64'hF1), 48'h1F, 0);
    idle(3);

    // Reset while FIFOs hold data.
    out_ready = 5'h00;
    send(mk(3'b000, 64'h51), 48'h1F, 0);
    send(mk(3'b001, 64'h52), 48'h1F, 1);
    #2;
    chk("pre_reset_valid", 64'(out_valid), 64'h3);
    rst = 1'b1;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'h0);
    chk("async_reset_counters", {32'h0, tt_order_err, src_err}, 64'h0);
    chk("async_reset_pk", 64'(period_known), 64'h0);
    for (int k = 0; k < 5; k++) q[k].delete();
    idle(2);
    rst = 1'b0;
    out_ready = 5'h1f;
    idle(1);
    send(mk(3'b010, 64'h77), 48'h0, 2);
    idle(4);

    for (int k = 0; k < 5; k++) chk($sformatf("queue_empty_ch%0d", k), 64'(q[k].size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/block_demultiplexer.md
Name: block_demultiplexer

Overview:
- Receive end of the merged front-end block stream. Takes the single 128-bit word stream that the block multiplexer produced (blocks 1-4 plus time tags, already in period order) and splits it back into per-block channels and a time-tag channel.
- Rebuilds a 48-bit period for every block word from the most recent time tag.
- Buffers each output channel independently, so a stalled consumer blocks only words bound for that channel.
- Counts protocol errors.
- Sits on the backend side of the frontend link, feeding per-block processing and the timing logic.

Parameters:
- DEPTH, 2, entries per output channel FIFO (power of two, >=2)
- ERR_W, 16, width of each saturating error counter

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  merged word valid
- in_data  in  128  merged word
- in_ready  out  1  merged word accepted when in_valid & in_ready
- out_valid  out  5  per channel; bits 0-3 = blocks 1-4, bit 4 = time tag
- out_ready  in  5  per-channel consumer ready
- out_data  out  640  channel k in [128k+127:128k], word unmodified
- out_period  out  240  channel k in [48k+47:48k]
- period_known  out  1  at least one time tag accepted since reset
- tt_order_err  out  ERR_W  count of non-increasing time tags
- src_err  out  ERR_W  count of words with an invalid source field

Behaviour:
- Word format is fixed:
  - in_data[127:125] is the source: 3'b000-3'b011 = block 1-4, 3'b100 = time tag, 3'b101-3'b111 invalid.
  - A time tag carries its period in in_data[47:0].
- Reset value of every output is 0: out_valid, period_known, both counters, and all FIFO contents/pointers.
- Destination decode is combinational from in_data:
  - in_ready = ~full[dest] for a valid source.
  - in_ready = 1 for an invalid source, so invalid words are always consumed.
- On accept of a valid-source word, it is written to FIFO[dest] together with its period:
  - Time tag period = in_data[47:0].
  - Block period = cur_period, the register value before this cycle's update.
- On accept of a time tag:
  - cur_period <= in_data[47:0] and period_known <= 1.
  - If period_known was already 1 and in_data[47:0] <= cur_period, increment tt_order_err (saturate at all-ones).
  - The tag is still forwarded and still updates cur_period.
- Block words accepted before the first time tag get period 0; period_known = 0 flags this condition.
- Invalid source on accept:
  - Word dropped and src_err increments (saturating).
  - No FIFO write, cur_period unchanged.
- Latency: an accepted word appears on out_valid[k] the next cycle if FIFO[k] was empty (registered FIFO output, no fall-through).
- Per-channel handshake:
  - Pop on out_valid[k] & out_ready[k].
  - out_data and out_period hold stable while out_valid[k] & ~out_ready[k].
- Simultaneous push and pop on a full FIFO is not allowed: in_ready uses the registered full flag, with no same-cycle pop credit.
- Simultaneous push and pop on a non-full FIFO is allowed; occupancy is unchanged.
- Pointer wrap: pointers are log2(DEPTH)+1 bits.
  - full = (wr^rd) == {1'b1, 0...}
  - empty = (wr == rd)
- Ordering is preserved within each channel. There are no ordering guarantees across channels.
- Reset asserted mid-transfer:
  - Immediately clears all FIFOs, cur_period, period_known and counters.
  - In-flight data is lost.
  - in_ready may be high during reset only if ~rst gated: in_ready = 0 while rst.

Decomposition:
- Package block_pkg:
  - Source code constants SRC_B1..SRC_B4 and SRC_TT.
  - Field positions SRC_HI=127, SRC_LO=125, PERIOD_W=48, DATA_W=128.
  - Channel count NCH=5.
- Sub-module block_chan_fifo:
  - Synchronous FIFO, width 176 (data + period), depth DEPTH.
  - Provides valid/ready on both sides, full, and empty.
  - Instantiated 5 times via generate.
- The top level holds the decode, cur_period, and the error counters.

Test Plan:
- Time tag period 0x10, then block-2 word, block-4 word, all consumers ready:
  - out_valid[4] with period 0x10.
  - out_valid[1] and out_valid[3], each with period 0x10.
  - Each appears 1 cycle after its accept.
  - period_known = 1.
- Block-1 word before any time tag:
  - Delivered with out_period[47:0] = 0.
  - period_known = 0.
  - No counter changes.
- out_ready[0] = 0; push 3 block-1 words with DEPTH=2:
  - in_ready drops after the 2nd accept.
  - A block-3 word behind it stalls until out_ready[0] = 1.
  - Data is then delivered in order.
- Time tags 0x20, 0x20, 0x1F:
  - tt_order_err = 2.
  - All three are forwarded.
  - Final cur_period = 0x1F, visible on the next block word.
- Word with source 3'b110 and in_valid = 1:
  - in_ready = 1.
  - src_err = 1.
  - No out_valid asserted.
  - cur_period unchanged.
- Assert rst while FIFOs hold data:
  - All out_valid = 0 and counters = 0 in the same cycle (async).
  - After release, the first block word carries period 0.
